alu_src_b_stage: RTL and testbench
==================================

Name: alu_src_b_stage

Overview:
Parametrised, registered successor to the ALU operand-B selector in the multicycle datapath. Picks operand B from register B, the PC increment constant, or one of several immediate forms. Builds all immediate extensions internally from the raw instruction immediate. Presents the result through a one-entry valid/ready output register so the ALU side can stall, and flags illegal select codes with a sticky error.

Parameters:
DATA_W, 32, operand width in bits
IMM_W, 16, raw immediate width; must be at least 2 and at most DATA_W
PC_INC, 4, constant produced for select 001
BR_SHIFT, 2, left-shift amount for select 011; must be less than DATA_W

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request carries a valid select and operands this cycle
in_ready  output  1  stage can accept a request this cycle
alu_src_b  input  3  operand-B select code
in_reg_b  input  DATA_W  register B value
in_imm  input  IMM_W  raw instruction immediate
out_valid  output  1  out_data holds a valid operand
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  DATA_W  registered operand B
out_sel  output  3  select code that produced out_data
err_illegal  output  1  sticky flag: an illegal select was accepted
err_clr  input  1  clears err_illegal

Behaviour:
- Reset values (synchronous; reset has priority over all other inputs): out_data=0, out_sel=0, out_valid=0, err_illegal=0.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept condition: in_valid && in_ready on a rising edge.
  - On accept, the next-cycle values are out_data=f(alu_src_b), out_sel=alu_src_b, out_valid=1.
  - Latency is exactly 1 cycle.
- out_valid && out_ready with no accept: out_valid drops to 0. out_data and out_sel hold their last values.
- out_valid && !out_ready: out_data, out_sel and out_valid are frozen. Inputs are ignored because in_ready=0.
- Simultaneous drain and accept: the new value is loaded and out_valid stays 1. Back-to-back throughput is 1 per cycle.
- Define sext = in_imm sign-extended to DATA_W and zext = in_imm zero-extended to DATA_W.
- Select map f:
  - 000: in_reg_b
  - 001: PC_INC, truncated to DATA_W
  - 010: sext
  - 011: sext << BR_SHIFT (logical, width DATA_W, high bits discarded)
  - 100: 0
  - 101: zext
  - 110: in_imm in the MSBs, with DATA_W-IMM_W zeros below
  - 111: illegal; loads 0
- err_illegal:
  - Set on an accept with alu_src_b=111.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - No set without an accept: an illegal code with in_valid=0, or while stalled, has no effect.
- Reset mid-stall discards the held operand; out_valid=0 on the next cycle.
- All operand inputs are sampled only on accept. No combinational path from inputs to out_data or out_sel.

Test Plan:
- Reset, then 4 consecutive accepts with sel=000/001/010/011, in_reg_b=0xDEADBEEF, in_imm=0xFFFC, out_ready=1 -> out_data sequence 0xDEADBEEF, 0x00000004, 0xFFFFFFFC, 0xFFFFFFF0, one cycle after each accept. out_valid held 1 throughout, in_ready constantly 1.
- Accept sel=101 then sel=110 with in_imm=0x8001 -> out_data 0x00008001, then 0x80010000. Accept sel=100 -> 0x00000000.
- Accept sel=010 with in_imm=0x1234 while out_ready=0 for 3 cycles, changing in_imm to 0xFFFF each cycle -> out_data stays 0x00001234 and in_ready=0 during the stall. Raise out_ready -> out_valid drops the next cycle when in_valid=0.
- Accept sel=111 -> out_data=0, out_sel=7, err_illegal=1 and stays 1 across later legal requests. Pulse err_clr together with another sel=111 accept -> err_illegal remains 1. Pulse err_clr alone -> 0.
- Hold out_valid=1 with out_ready=0, assert reset for 1 cycle -> next cycle out_valid=0, out_data=0, err_illegal=0, in_ready=1.
- DATA_W=16, IMM_W=8, PC_INC=2, BR_SHIFT=1, in_imm=0x80 -> sel 010=0xFF80, 011=0xFF00, 110=0x8000, 001=0x0002.

Source files
------------

// File: rtl/alu_src_b_stage.sv
// Operand-B selector for the multicycle datapath. It builds the immediate forms
// and holds the selected operand in a one-entry valid/ready output register.
module alu_src_b_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_src_b,
  input  logic [DATA_W-1:0] in_reg_b,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_sel,
  output logic              err_illegal,
  input  logic              err_clr
);

  localparam int unsigned HiShift = DATA_W - IMM_W;

  logic              accept;
  logic              isIllegal;
  logic [DATA_W-1:0] immSext;
  logic [DATA_W-1:0] immZext;
  logic [DATA_W-1:0] nextOperand;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Casting the signed immediate sign-extends it without a replication, so IMM_W == DATA_W is still legal.
  assign immSext = DATA_W'($signed(in_imm));
  assign immZext = DATA_W'(in_imm);

  always_comb begin
    nextOperand = '0;
    isIllegal   = 1'b0;
    case (alu_src_b)
      3'b000:  nextOperand = in_reg_b;
      3'b001:  nextOperand = DATA_W'(PC_INC);
      3'b010:  nextOperand = immSext;
      3'b011:  nextOperand = immSext << BR_SHIFT;
      3'b100:  nextOperand = '0;
      3'b101:  nextOperand = immZext;
      3'b110:  nextOperand = immZext << HiShift;
      default: begin
        nextOperand = '0;
        isIllegal   = 1'b1;
      end
    endcase
  end

  // Output register. A drain with no new accept keeps the data and drops only valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_sel     <= '0;
      out_valid   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= nextOperand;
        out_sel   <= alu_src_b;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && isIllegal) begin
        err_illegal <= 1'b1;
      end else if (err_clr) begin
        err_illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed self-checking bench for alu_src_b_stage, default and narrow configurations.
module tb_alu_src_b_stage;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  // Default configuration
  logic        inValid, inReady, outValid, outReady, errIllegal, errClr;
  logic [2:0]  sel, outSel;
  logic [31:0] regB, outData;
  logic [15:0] imm;

  // Narrow configuration
  logic        inValidN, inReadyN, outValidN, outReadyN, errIllegalN, errClrN;
  logic [2:0]  selN, outSelN;
  logic [15:0] regBN, outDataN;
  logic [7:0]  immN;

  always #5 clk = ~clk;

  alu_src_b_stage dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .alu_src_b(sel), .in_reg_b(regB), .in_imm(imm), .out_valid(outValid),
    .out_ready(outReady), .out_data(outData), .out_sel(outSel),
    .err_illegal(errIllegal), .err_clr(errClr)
  );

  alu_src_b_stage #(.DATA_W(16), .IMM_W(8), .PC_INC(2), .BR_SHIFT(1)) dutN (
    .clk(clk), .reset(reset), .in_valid(inValidN), .in_ready(inReadyN),
    .alu_src_b(selN), .in_reg_b(regBN), .in_imm(immN), .out_valid(outValidN),
    .out_ready(outReadyN), .out_data(outDataN), .out_sel(outSelN),
    .err_illegal(errIllegalN), .err_clr(errClrN)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    checks++;
    if (outData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", outData); end
    checks++;
    if (outSel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", outSel); end
    checks++;
    if (errIllegal !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", errIllegal); end
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", inReady); end
    checks++;
    if (outValidN !== 1'b0 || outDataN !== 16'h0) begin
      failures++; $display("FAIL reset_narrow valid=%b data=%h exp valid=0 data=0", outValidN, outDataN);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expData [4] = '{32'hDEADBEEF, 32'h00000004, 32'hFFFFFFFC, 32'hFFFFFFF0};
    inValid  = 1'b1;
    outReady = 1'b1;
    regB     = 32'hDEADBEEF;
    imm      = 16'hFFFC;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      checks++;
      if (inReady !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, inReady); end
      step();
      checks++;
      if (outData !== expData[i] || outValid !== 1'b1 || outSel !== 3'(i)) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%h valid=%b sel=%0d exp=%h valid=1 sel=%0d",
                 i, outData, outValid, outSel, expData[i], i);
      end
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_imm_forms();
    logic [2:0]  sels [3] = '{3'd5, 3'd6, 3'd4};
    logic [31:0] expData [3] = '{32'h00008001, 32'h80010000, 32'h00000000};
    inValid  = 1'b1;
    outReady = 1'b1;
    imm      = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      step();
      checks++;
      if (outData !== expData[i] || outValid !== 1'b1) begin
        failures++;
        $display("FAIL imm_form[%0d] got=%h valid=%b exp=%h valid=1", i, outData, outValid, expData[i]);
      end
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    inValid  = 1'b1;
    outReady = 1'b0;
    sel      = 3'd2;
    imm      = 16'h1234;
    step();
    checks++;
    if (outData !== 32'h00001234 || outValid !== 1'b1) begin
      failures++; $display("FAIL stall_load got=%h valid=%b exp=00001234 valid=1", outData, outValid);
    end
    for (int i = 0; i < 3; i++) begin
      imm = 16'hFFFF;
      checks++;
      if (inReady !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, inReady); end
      step();
      checks++;
      if (outData !== 32'h00001234 || outValid !== 1'b1 || outSel !== 3'd2) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h valid=%b sel=%0d exp=00001234 valid=1 sel=2",
                 i, outData, outValid, outSel);
      end
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h00001234) begin
      failures++; $display("FAIL stall_drain valid=%b data=%h exp valid=0 data=00001234", outValid, outData);
    end
  endtask

  task automatic test_illegal();
    inValid  = 1'b0;
    outReady = 1'b1;
    sel      = 3'd7;
    step();
    checks++;
    if (errIllegal !== 1'b0) begin failures++; $display("FAIL illegal_no_valid got=%b exp=0", errIllegal); end
    // Illegal code offered while stalled must not set the flag
    inValid  = 1'b1;
    outReady = 1'b0;
    sel      = 3'd0;
    regB     = 32'hDEADBEEF;
    step();
    sel = 3'd7;
    step();
    checks++;
    if (errIllegal !== 1'b0 || outSel !== 3'd0) begin
      failures++; $display("FAIL illegal_stalled err=%b sel=%0d exp err=0 sel=0", errIllegal, outSel);
    end
    outReady = 1'b1;
    step();
    checks++;
    if (outData !== 32'h0 || outSel !== 3'd7 || errIllegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_accept data=%h sel=%0d err=%b exp data=0 sel=7 err=1", outData, outSel, errIllegal);
    end
    sel = 3'd0;
    step();
    checks++;
    if (errIllegal !== 1'b1 || outData !== 32'hDEADBEEF) begin
      failures++; $display("FAIL illegal_sticky err=%b data=%h exp err=1 data=deadbeef", errIllegal, outData);
    end
    sel    = 3'd7;
    errClr = 1'b1;
    step();
    checks++;
    if (errIllegal !== 1'b1) begin failures++; $display("FAIL illegal_set_wins got=%b exp=1", errIllegal); end
    inValid = 1'b0;
    step();
    errClr = 1'b0;
    checks++;
    if (errIllegal !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b exp=0", errIllegal); end
  endtask

  task automatic test_reset_mid_stall();
    inValid  = 1'b1;
    outReady = 1'b1;
    sel      = 3'd7;
    step();
    outReady = 1'b0;
    sel      = 3'd0;
    regB     = 32'hCAFEF00D;
    step();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || errIllegal !== 1'b1) begin
      failures++; $display("FAIL midstall_setup valid=%b err=%b exp valid=1 err=1", outValid, errIllegal);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (outValid !== 1'b0 || outData !== 32'h0 || errIllegal !== 1'b0 || inReady !== 1'b1) begin
      failures++;
      $display("FAIL midstall_reset valid=%b data=%h err=%b in_ready=%b exp 0 0 0 1",
               outValid, outData, errIllegal, inReady);
    end
    outReady = 1'b1;
  endtask

  task automatic test_narrow();
    logic [2:0]  sels [5] = '{3'd2, 3'd3, 3'd6, 3'd1, 3'd5};
    logic [15:0] expData [5] = '{16'hFF80, 16'hFF00, 16'h8000, 16'h0002, 16'h0080};
    inValidN  = 1'b1;
    outReadyN = 1'b1;
    immN      = 8'h80;
    for (int i = 0; i < 5; i++) begin
      selN = sels[i];
      step();
      checks++;
      if (outDataN !== expData[i] || outValidN !== 1'b1) begin
        failures++;
        $display("FAIL narrow[%0d] sel=%0d got=%h valid=%b exp=%h valid=1",
                 i, sels[i], outDataN, outValidN, expData[i]);
      end
    end
    inValidN = 1'b0;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    inValid   = 1'b0; outReady  = 1'b1; errClr  = 1'b0;
    sel       = 3'd0; regB      = '0;   imm     = '0;
    inValidN  = 1'b0; outReadyN = 1'b1; errClrN = 1'b0;
    selN      = 3'd0; regBN     = '0;   immN    = '0;
    step();
    test_reset();
    test_back_to_back();
    test_imm_forms();
    test_stall();
    test_illegal();
    test_reset_mid_stall();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
